// File: rtl/ntt_butterfly.sv
// Pipelined modular NTT butterfly: reads A then B/twiddle, writes X then Y back to memory.
// Define NTT_BFLY_INTT_EN to add the inv port selecting the Gentleman-Sande (inverse) butterfly.
module ntt_butterfly #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned Q      = 12289
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] twiddle,
`ifdef NTT_BFLY_INTT_EN
    input  logic              inv,
`endif
    output logic              in_ready,
    output logic              wr_valid,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              err
);

    localparam int unsigned       PW = 2 * DATA_W;
    localparam logic [DATA_W:0]   QS = (DATA_W + 1)'(Q);
    localparam logic [DATA_W-1:0] QD = DATA_W'(Q);
    localparam logic [PW-1:0]     QP = PW'(Q);

    typedef enum logic [2:0] {StIdle, StHaveA, StMul1, StMul2, StWrX, StWrY} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, b_q, w_q, t_q;
    logic [PW-1:0]     prod_q, product;
    logic              err_q, inv_q;
    logic              accept, range_err;
    logic [DATA_W:0]   diff, sum, sub;
    logic [DATA_W-1:0] mul_op, add_op;

    function automatic logic [DATA_W-1:0] reduce(input logic [PW-1:0] v);
        logic [PW-1:0] r;
        r = v % QP;
        return r[DATA_W-1:0];
    endfunction

    assign in_ready  = (state_q == StIdle) || (state_q == StHaveA);
    assign busy      = (state_q != StIdle);
    assign err       = err_q;
    assign accept    = rd_valid && in_ready;
    assign range_err = accept && ((rd_data >= QD) || ((state_q == StHaveA) && (twiddle >= QD)));

    // Operands are stored already reduced so every later sum/difference needs one correction only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            w_q     <= '0;
            t_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_q | range_err | (rd_valid & ~in_ready);
            if (accept && (state_q == StIdle)) begin
                a_q <= reduce(PW'(rd_data));
            end
            if (accept && (state_q == StHaveA)) begin
                b_q <= reduce(PW'(rd_data));
                w_q <= twiddle;
            end
            if (state_q == StMul1) begin
                prod_q <= product;
            end
            if (state_q == StMul2) begin
                t_q <= reduce(prod_q);
            end
        end
    end

`ifdef NTT_BFLY_INTT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (accept && (state_q == StHaveA)) begin
            inv_q <= inv;
        end
    end
`else
    assign inv_q = 1'b0;
`endif

    always_comb begin
        diff = {1'b0, a_q} - {1'b0, b_q};
        if (diff[DATA_W]) begin
            diff = diff + QS;
        end
        // Inverse butterfly multiplies the difference; forward multiplies B.
        mul_op  = inv_q ? diff[DATA_W-1:0] : b_q;
        product = PW'(mul_op) * PW'(w_q);
        add_op  = inv_q ? b_q : t_q;
        sum     = {1'b0, a_q} + {1'b0, add_op};
        if (sum >= QS) begin
            sum = sum - QS;
        end
        sub = {1'b0, a_q} - {1'b0, t_q};
        if (sub[DATA_W]) begin
            sub = sub + QS;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_valid = 1'b0;
        wr_data  = '0;
        unique case (state_q)
            StIdle:  if (rd_valid) state_d = StHaveA;
            StHaveA: if (rd_valid) state_d = StMul1;
            StMul1:  state_d = StMul2;
            StMul2:  state_d = StWrX;
            StWrX: begin
                wr_valid = 1'b1;
                wr_data  = sum[DATA_W-1:0];
                state_d  = StWrY;
            end
            StWrY: begin
                wr_valid = 1'b1;
                wr_data  = inv_q ? t_q : sub[DATA_W-1:0];
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly: directed corner cases plus random butterflies
// compared against an integer-arithmetic reference model.
module tb_ntt_butterfly;

    localparam int DW = 14;
    localparam int Q  = 12289;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] twiddle;
`ifdef NTT_BFLY_INTT_EN
    logic          inv;
`endif
    logic          in_ready;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    ntt_butterfly #(.DATA_W(DW), .Q(Q)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .twiddle  (twiddle),
`ifdef NTT_BFLY_INTT_EN
        .inv      (inv),
`endif
        .in_ready (in_ready),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference butterfly from the modular-arithmetic definition.
    task automatic model(input longint a, input longint b, input longint w, input bit iv,
                         output longint x, output longint y);
        longint ar, br, t;
        ar = a % Q;
        br = b % Q;
        if (iv) begin
            x = (ar + br) % Q;
            y = ((((ar - br) % Q) + Q) % Q * (w % Q)) % Q;
        end else begin
            t = (br * w) % Q;
            x = (ar + t) % Q;
            y = (((ar - t) % Q) + Q) % Q;
        end
    endtask

    // One full butterfly with per-cycle output checks; poke holds rd_valid into MUL1.
    task automatic run_bfly(input int a, input int b, input int w, input bit iv,
                            input bit poke, input int gap);
        longint ex, ey;
        model(a, b, w, iv, ex, ey);
        @(negedge clk);
        rd_valid = 1'b1;
        rd_data  = a[DW-1:0];
        @(negedge clk);
        check("have_a_ready", in_ready, 1);
        check("have_a_busy", busy, 1);
        rd_valid = 1'b0;
        repeat (gap) @(negedge clk);
        check("have_a_hold", in_ready, 1);
        rd_valid = 1'b1;
        rd_data  = b[DW-1:0];
        twiddle  = w[DW-1:0];
`ifdef NTT_BFLY_INTT_EN
        inv = iv;
`endif
        @(negedge clk);
        check("mul1_ready", in_ready, 0);
        check("mul1_wr_valid", wr_valid, 0);
        if (!poke) rd_valid = 1'b0;
        @(negedge clk);
        rd_valid = 1'b0;
        check("mul2_wr_valid", wr_valid, 0);
        check("mul2_wr_data", wr_data, 0);
        @(negedge clk);
        check("x_valid", wr_valid, 1);
        check("x_data", wr_data, 32'(ex));
        @(negedge clk);
        check("y_valid", wr_valid, 1);
        check("y_data", wr_data, 32'(ey));
        @(negedge clk);
        check("done_wr_valid", wr_valid, 0);
        check("done_busy", busy, 0);
        check("done_ready", in_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rd_valid = 1'b1;
        rd_data  = 14'd7;
        @(negedge clk);
        rst      = 1'b0;
        rd_valid = 1'b0;
    endtask

    initial begin
        int a, b, w;
        bit iv;
        rst      = 1'b1;
        rd_valid = 1'b0;
        rd_data  = '0;
        twiddle  = '0;
`ifdef NTT_BFLY_INTT_EN
        inv      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        do_reset();
        check("rst_ready", in_ready, 1);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);

        run_bfly(5, 3, 2, 1'b0, 1'b0, 0);
        run_bfly(12288, 1, 1, 1'b0, 1'b0, 3);
        check("no_err_yet", err, 0);
        run_bfly(0, 12288, 12288, 1'b0, 1'b1, 0);
        check("err_ignored_beat", err, 1);
        repeat (3) @(negedge clk);
        check("err_sticky", err, 1);
        check("ignored_beat_idle", busy, 0);

        do_reset();
        check("err_cleared", err, 0);

        // Reset while in MUL2 discards the butterfly.
        @(negedge clk);
        rd_valid = 1'b1;
        rd_data  = 14'd100;
        @(negedge clk);
        rd_data  = 14'd200;
        twiddle  = 14'd300;
        @(negedge clk);
        rd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mul2_rst_wr_valid", wr_valid, 0);
        check("mul2_rst_ready", in_ready, 1);
        check("mul2_rst_busy", busy, 0);
        @(negedge clk);
        check("mul2_rst_no_pulse", wr_valid, 0);
        run_bfly(5, 3, 2, 1'b0, 1'b0, 0);

`ifdef NTT_BFLY_INTT_EN
        run_bfly(5, 3, 2, 1'b1, 1'b0, 0);
        run_bfly(3, 5, 1, 1'b1, 1'b0, 0);
`endif

        for (int i = 0; i < 24; i++) begin
            a  = int'($urandom_range(Q - 1, 0));
            b  = int'($urandom_range(Q - 1, 0));
            w  = int'($urandom_range(Q - 1, 0));
            iv = 1'b0;
`ifdef NTT_BFLY_INTT_EN
            iv = 1'($urandom_range(1, 0));
`endif
            run_bfly(a, b, w, iv, 1'b0, int'($urandom_range(2, 0)));
        end
        check("random_no_err", err, 0);

        run_bfly(12289, 7, 100, 1'b0, 1'b0, 0);
        check("range_err_a", err, 1);

        do_reset();
        run_bfly(int'($urandom_range(Q - 1, 0)), 16383, 16383, 1'b0, 1'b0, 0);
        check("range_err_b", err, 1);

        do_reset();
        run_bfly(42, 9, 16000, 1'b0, 1'b0, 1);
        check("range_err_w", err, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_butterfly.md
NTT_BUTTERFLY -- requirements
Module: ntt_butterfly

Interface
REQ-001 SHALL have parameter DATA_W, default 14, coefficient/twiddle width in bits.
REQ-002 SHALL have parameter Q, default 12289, prime modulus; Q < 2^DATA_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rd_valid  input  1  rd_data holds a coefficient read from memory this cycle.
REQ-006 SHALL have port rd_data  input  DATA_W  coefficient read from memory.
REQ-007 SHALL have port twiddle  input  DATA_W  twiddle factor w; sampled only with the second operand.
REQ-008 SHALL have port in_ready  output  1  block accepts rd_valid beats this cycle.
REQ-009 SHALL have port wr_valid  output  1  wr_data is to be written to memory this cycle.
REQ-010 SHALL have port wr_data  output  DATA_W  butterfly result to write back.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port err  output  1  sticky protocol/range error flag.

Function
REQ-013 SHALL implement states IDLE, HAVE_A, MUL1, MUL2, WR_X, WR_Y.
REQ-014 SHALL drive in_ready high only in IDLE and HAVE_A.
REQ-015 IDLE: rd_valid -> capture A=rd_data, go HAVE_A; else stay.
REQ-016 HAVE_A: rd_valid -> capture B=rd_data and w=twiddle, go MUL1; else stay (no timeout).
REQ-017 MUL1, MUL2: two-cycle pipeline computing t = (B*w) mod Q from the full 2*DATA_W-bit product; unconditional advance MUL1->MUL2->WR_X.
REQ-018 WR_X: wr_valid=1, wr_data = (A + t) mod Q; go WR_Y.
REQ-019 WR_Y: wr_valid=1, wr_data = (A - t) mod Q, in [0,Q) via add of Q on borrow; go IDLE.
REQ-020 Fixed latency: second operand accepted at cycle n -> X at n+3, Y at n+4; one butterfly per 6 cycles minimum.
REQ-021 wr_valid SHALL be 0 and wr_data SHALL be 0 outside WR_X/WR_Y.
REQ-022 rd_valid while in_ready=0 SHALL be ignored (no state change) and SHALL set err.
REQ-023 rd_data or twiddle >= Q on an accepted beat SHALL set err; computation continues with full reduction so outputs always lie in [0,Q).
REQ-024 All intermediate sums use DATA_W+1 bits; no truncation before reduction.
REQ-025 err SHALL stay set until rst.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, clear A, B, w, pipeline registers and err, regardless of state (mid-butterfly results discarded, no partial write).
REQ-027 Outputs during/after reset: in_ready=1, wr_valid=0, wr_data=0, busy=0, err=0.
REQ-028 rd_valid asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-029 Macro NTT_BFLY_INTT_EN: when defined, SHALL add input port inv (1 bit, sampled with the second operand) selecting Gentleman-Sande butterfly: X = (A + B) mod Q, Y = ((A - B) mod Q * w) mod Q, same state sequence and latency; inv=0 behaves as REQ-018/019.
REQ-030 Without NTT_BFLY_INTT_EN: no inv port; Cooley-Tukey only.

Verification
REQ-031 A=5, B=3, w=2 -> wr_data 11 at n+3, 12288 at n+4, wr_valid high exactly those two cycles.
REQ-032 A=12288, B=1, w=1 -> X=0 (wrap), Y=12287.
REQ-033 A=0, B=12288, w=12288 -> t=1, X=1, Y=12288; then rd_valid during MUL1 -> ignored, err=1 and held until rst.
REQ-034 Reset asserted in MUL2 -> next cycle IDLE, no wr_valid pulse, in_ready=1; fresh butterfly afterwards gives correct results.
REQ-035 With NTT_BFLY_INTT_EN, inv=1, A=5, B=3, w=2 -> X=8, Y=4; A=3, B=5, w=1 -> X=8, Y=12287.
REQ-036 rd_data=12289 accepted -> err=1, outputs still < Q.
